// File: rtl/mem_bus_port.sv
// LC-3 memory bus port: MAR/MDR latches, req/ack memory cycle with timeout,
// and gated MDR return path toward the system bus tribuf.
module mem_bus_port #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic             gate_mdr,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             ready,
  output logic             err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_req,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             req_q, req_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    ready_d = ready_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr && !mio_en) mdr_d = bus_in;
        if (mio_en) begin
          addr_d  = mar_q;
          wdata_d = mdr_q;
          we_d    = r_w;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = r_w ? S_WR : S_RD;
        end
      end
      S_RD, S_WR: begin
        // ack wins over a timeout landing on the same edge
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (state_q == S_RD) mdr_d = mem_rdata;
          ready_d = mio_en;
          state_d = mio_en ? S_DONE : S_IDLE;
        end else if (cnt_last) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          ready_d = mio_en;
          state_d = mio_en ? S_DONE : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr && !mio_en) mdr_d = bus_in;
        if (!mio_en) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out   = mdr_q;
  assign bus_oe    = gate_mdr;
  assign ready     = ready_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_req   = req_q;

endmodule

// File: tb/tb_mem_bus_port.sv
// Scoreboard bench for mem_bus_port: expected memory transactions are queued
// when a cycle is requested and checked when mem_req appears.
module tb_mem_bus_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  logic [15:0] bus_out;
  logic        bus_oe, ready, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, mem_req;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] mdr;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_bus_port #(.WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
    .r_w(r_w), .gate_mdr(gate_mdr), .bus_out(bus_out),
    .bus_oe(bus_oe), .ready(ready), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0;
    mio_en = 0; r_w = 0; gate_mdr = 1; mem_rdata = '0; mem_ack = 0;
    #2;
    n_cmp++;
    if ({mem_req, mem_we, ready, err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 0000",
               {mem_req, mem_we, ready, err});
    end
    n_cmp++;
    if ({bus_out, mem_addr, mem_wdata} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0",
               {bus_out, mem_addr, mem_wdata});
    end
    n_cmp++;
    if (bus_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_oe got %b want 1", bus_oe);
    end
    tick();
    rst = 1'b0;
    gate_mdr = 0;
    tick();
  endtask

  task automatic test_bus_load();
    bus_in = 16'h3000; ld_mar = 1;
    tick();
    ld_mar = 0; bus_in = 16'hFFFF; ld_mdr = 1;
    tick();
    ld_mdr = 0; gate_mdr = 1;
    #1;
    n_cmp++;
    if ({bus_out, bus_oe} !== {16'hFFFF, 1'b1}) begin
      n_bad++;
      $display("FAIL gate_on got %h/%b want ffff/1", bus_out, bus_oe);
    end
    gate_mdr = 0;
    #1;
    n_cmp++;
    if (bus_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_off got %b want 0", bus_oe);
    end
    gate_mdr = 1; ld_mdr = 1; bus_in = 16'h5555;
    #1;
    n_cmp++;
    if (bus_out !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL gate_old_mdr got %h want ffff", bus_out);
    end
    tick();
    ld_mdr = 0; gate_mdr = 0;
    n_cmp++;
    if (bus_out !== 16'h5555) begin
      n_bad++;
      $display("FAIL gate_new_mdr got %h want 5555", bus_out);
    end
  endtask

  task automatic test_read();
    exp_q.push_back('{16'h3000, 1'b0, 16'h5555, 16'h1234});
    mio_en = 1; r_w = 0;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !==
        {1'b1, cur.addr, cur.we, cur.wdata}) begin
      n_bad++;
      $display("FAIL rd_start got %b %h %b %h want 1 %h %b %h",
               mem_req, mem_addr, mem_we, mem_wdata,
               cur.addr, cur.we, cur.wdata);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({mem_req, ready} !== 2'b10) begin
        n_bad++;
        $display("FAIL rd_hold%0d got %b want 10", k, {mem_req, ready});
      end
    end
    mem_ack = 1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 0; mem_rdata = '0;
    n_cmp++;
    if ({mem_req, ready, err, bus_out} !== {3'b010, cur.mdr}) begin
      n_bad++;
      $display("FAIL rd_done got %b%b%b %h want 010 %h",
               mem_req, ready, err, bus_out, cur.mdr);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_ready_hold got %b want 1", ready);
    end
    mio_en = 0;
    tick();
    n_cmp++;
    if ({ready, mem_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_idle got %b want 00", {ready, mem_req});
    end
  endtask

  task automatic test_write();
    bus_in = 16'h4000; ld_mar = 1;
    tick();
    ld_mar = 0; bus_in = 16'hABCD; ld_mdr = 1;
    tick();
    ld_mdr = 0;
    exp_q.push_back('{16'h4000, 1'b1, 16'hABCD, 16'hABCD});
    mio_en = 1; r_w = 1;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !==
        {1'b1, cur.addr, cur.we, cur.wdata}) begin
      n_bad++;
      $display("FAIL wr_start got %b %h %b %h want 1 %h %b %h",
               mem_req, mem_addr, mem_we, mem_wdata,
               cur.addr, cur.we, cur.wdata);
    end
    tick();
    mem_ack = 1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    n_cmp++;
    if ({mem_req, mem_we, ready, bus_out} !== {3'b001, cur.mdr}) begin
      n_bad++;
      $display("FAIL wr_done got %b%b%b %h want 001 %h",
               mem_req, mem_we, ready, bus_out, cur.mdr);
    end
    mio_en = 0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    exp_q.push_back('{16'h4000, 1'b1, 16'hABCD, 16'hABCD});
    mio_en = 1; r_w = 1;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !==
        {1'b1, cur.addr, cur.we, cur.wdata}) begin
      n_bad++;
      $display("FAIL to_ack_start got %b %h %b %h want 1 %h %b %h",
               mem_req, mem_addr, mem_we, mem_wdata,
               cur.addr, cur.we, cur.wdata);
    end
    tick(); tick(); tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    n_cmp++;
    if ({mem_req, ready, err} !== 3'b010) begin
      n_bad++;
      $display("FAIL to_ack_last got %b want 010", {mem_req, ready, err});
    end
    mio_en = 0;
    tick();
    tick();
    exp_q.push_back('{16'h4000, 1'b0, 16'hABCD, 16'hABCD});
    mio_en = 1; r_w = 0;
    tick();
    cur = exp_q.pop_front();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      n++;
      tick();
    end
    n_cmp++;
    if (n != 4) begin
      n_bad++;
      $display("FAIL to_req_cycles got %0d want 4", n);
    end
    n_cmp++;
    if ({err, ready, bus_out} !== {2'b11, cur.mdr}) begin
      n_bad++;
      $display("FAIL to_flags got %b%b %h want 11 %h",
               err, ready, bus_out, cur.mdr);
    end
    mio_en = 0;
    tick();
    n_cmp++;
    if ({err, ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL to_sticky got %b want 10", {err, ready});
    end
  endtask

  task automatic test_abort();
    bus_in = 16'h2000; ld_mar = 1;
    tick();
    ld_mar = 0;
    exp_q.push_back('{16'h2000, 1'b0, 16'hABCD, 16'hBEEF});
    mio_en = 1; r_w = 0;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we} !== {1'b1, cur.addr, cur.we}) begin
      n_bad++;
      $display("FAIL ab_start got %b %h %b want 1 %h %b",
               mem_req, mem_addr, mem_we, cur.addr, cur.we);
    end
    mio_en = 0; ld_mar = 1; bus_in = 16'h1111;
    tick();
    ld_mar = 0;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL ab_hold got %b want 1", mem_req);
    end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    n_cmp++;
    if ({mem_req, ready, bus_out} !== {2'b00, cur.mdr}) begin
      n_bad++;
      $display("FAIL ab_done got %b%b %h want 00 %h",
               mem_req, ready, bus_out, cur.mdr);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_noready got %b want 0", ready);
    end
  endtask

  task automatic test_reset_mid_write();
    exp_q.push_back('{16'h2000, 1'b1, 16'hBEEF, 16'hBEEF});
    mio_en = 1; r_w = 1;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !==
        {1'b1, cur.addr, cur.we, cur.wdata}) begin
      n_bad++;
      $display("FAIL rw_start got %b %h %b %h want 1 %h %b %h",
               mem_req, mem_addr, mem_we, mem_wdata,
               cur.addr, cur.we, cur.wdata);
    end
    #2;
    rst = 1; gate_mdr = 1;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, ready, err, bus_oe} !== 5'b00001) begin
      n_bad++;
      $display("FAIL rw_async got %b want 00001",
               {mem_req, mem_we, ready, err, bus_oe});
    end
    n_cmp++;
    if ({bus_out, mem_addr} !== 32'h0) begin
      n_bad++;
      $display("FAIL rw_async_data got %h want 0", {bus_out, mem_addr});
    end
    #1;
    rst = 0; gate_mdr = 0; mio_en = 0;
    mem_ack = 1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 0; mem_rdata = '0;
    n_cmp++;
    if ({mem_req, ready, err, bus_out} !== 19'h0) begin
      n_bad++;
      $display("FAIL rw_stray_ack got %b%b%b %h want 000 0000",
               mem_req, ready, err, bus_out);
    end
    exp_q.push_back('{16'h0000, 1'b0, 16'h0000, 16'h0042});
    mio_en = 1; r_w = 0;
    tick();
    cur = exp_q.pop_front();
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !==
        {1'b1, cur.addr, cur.we, cur.wdata}) begin
      n_bad++;
      $display("FAIL rw_mar_zero got %b %h %b %h want 1 %h %b %h",
               mem_req, mem_addr, mem_we, mem_wdata,
               cur.addr, cur.we, cur.wdata);
    end
    mem_ack = 1; mem_rdata = 16'h0042;
    tick();
    mem_ack = 0; mem_rdata = '0;
    n_cmp++;
    if ({ready, bus_out} !== {1'b1, cur.mdr}) begin
      n_bad++;
      $display("FAIL rw_after got %b %h want 1 %h", ready, bus_out, cur.mdr);
    end
    mio_en = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_bus_load();
    test_read();
    test_write();
    test_timeout();
    test_abort();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
